// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: valid/ready TX and 16x-oversampled RX with parity/stop error flags.
// Build macro UART_LOOPBACK_EN adds a 'loopback' input that routes TX serial data into RX.
module uart_core_param #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int BAUD_DIV0 = 27,
    parameter int BAUD_DIV1 = 54,
    parameter int BAUD_DIV2 = 163,
    parameter int BAUD_DIV3 = 326
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        baud_sel,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
`ifdef UART_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_line,
    input  logic              rx_line,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_err,
    output logic              rx_stop_err
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DIV_W-1:0] div_sel;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       baud_sel_reg;
    logic             tick;

    always_comb begin
        case (baud_sel)
            2'd0:    div_sel = DIV_W'(BAUD_DIV0);
            2'd1:    div_sel = DIV_W'(BAUD_DIV1);
            2'd2:    div_sel = DIV_W'(BAUD_DIV2);
            default: div_sel = DIV_W'(BAUD_DIV3);
        endcase
    end

    // A baud_sel change restarts the divisor so the first new tick is a full period long.
    assign tick = (baud_sel == baud_sel_reg) && (div_cnt_reg == div_sel - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            baud_sel_reg <= '0;
        end else begin
            baud_sel_reg <= baud_sel;
            if ((baud_sel != baud_sel_reg) || tick)
                div_cnt_reg <= '0;
            else
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    state_t            tx_state_reg, tx_state_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic [3:0]        tx_bit_reg, tx_bit_next;
    logic [4:0]        tx_tick_reg, tx_tick_next;
    logic              tx_par_en_reg, tx_par_en_next;
    logic              tx_pbit_reg, tx_pbit_next;
    logic              tx_stop2_reg, tx_stop2_next;
    logic              tx_out_reg, tx_out_next;
    logic              tx_ready_reg, tx_ready_next;
    logic              tx_bit_end, tx_stop_end;

    always_comb begin
        tx_state_next  = tx_state_reg;
        tx_shift_next  = tx_shift_reg;
        tx_bit_next    = tx_bit_reg;
        tx_tick_next   = tx_tick_reg;
        tx_par_en_next = tx_par_en_reg;
        tx_pbit_next   = tx_pbit_reg;
        tx_stop2_next  = tx_stop2_reg;
        tx_out_next    = tx_out_reg;
        tx_ready_next  = tx_ready_reg;
        tx_bit_end     = tick && (tx_tick_reg == 5'd15);
        tx_stop_end    = tick && (tx_tick_reg == (tx_stop2_reg ? 5'd31 : 5'd15));
        if (tick)
            tx_tick_next = tx_tick_reg + 5'd1;
        case (tx_state_reg)
            S_IDLE: begin
                tx_out_next   = 1'b1;
                tx_ready_next = 1'b1;
                tx_tick_next  = '0;
                if (tx_valid && tx_ready_reg) begin
                    tx_state_next  = S_START;
                    tx_shift_next  = tx_data;
                    tx_par_en_next = parity_mode[0] ^ parity_mode[1];
                    // odd parity (2'b10) is the complement of even parity
                    tx_pbit_next   = (^tx_data) ^ parity_mode[1];
                    tx_stop2_next  = stop2;
                    tx_bit_next    = '0;
                    tx_out_next    = 1'b0;
                    tx_ready_next  = 1'b0;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_next = S_DATA;
                    tx_tick_next  = '0;
                    tx_out_next   = tx_shift_reg[0];
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_tick_next = '0;
                    if (tx_bit_reg == 4'(DATA_W - 1)) begin
                        tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
                        tx_out_next   = tx_par_en_reg ? tx_pbit_reg : 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 4'd1;
                        tx_shift_next = tx_shift_reg >> 1;
                        tx_out_next   = tx_shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_next = S_STOP;
                    tx_tick_next  = '0;
                    tx_out_next   = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_stop_end) begin
                    tx_state_next = S_IDLE;
                    tx_tick_next  = '0;
                    tx_ready_next = 1'b1;
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_reg  <= S_IDLE;
            tx_shift_reg  <= '0;
            tx_bit_reg    <= '0;
            tx_tick_reg   <= '0;
            tx_par_en_reg <= 1'b0;
            tx_pbit_reg   <= 1'b0;
            tx_stop2_reg  <= 1'b0;
            tx_out_reg    <= 1'b1;
            tx_ready_reg  <= 1'b0;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_shift_reg  <= tx_shift_next;
            tx_bit_reg    <= tx_bit_next;
            tx_tick_reg   <= tx_tick_next;
            tx_par_en_reg <= tx_par_en_next;
            tx_pbit_reg   <= tx_pbit_next;
            tx_stop2_reg  <= tx_stop2_next;
            tx_out_reg    <= tx_out_next;
            tx_ready_reg  <= tx_ready_next;
        end
    end

    logic              rx_src, rx_meta_reg, rx_sync_reg;
    state_t            rx_state_reg, rx_state_next;
    logic [3:0]        rx_tick_reg, rx_tick_next;
    logic [3:0]        rx_bit_reg, rx_bit_next;
    logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic [1:0]        rx_mode_reg, rx_mode_next;
    logic              rx_perr_reg, rx_perr_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              rx_perr_out_reg, rx_perr_out_next;
    logic              rx_serr_reg, rx_serr_next;
    logic              rx_sample;

    always_comb begin
        rx_state_next    = rx_state_reg;
        rx_tick_next     = rx_tick_reg;
        rx_bit_next      = rx_bit_reg;
        rx_shift_next    = rx_shift_reg;
        rx_data_next     = rx_data_reg;
        rx_mode_next     = rx_mode_reg;
        rx_perr_next     = rx_perr_reg;
        rx_valid_next    = 1'b0;
        rx_perr_out_next = rx_perr_out_reg;
        rx_serr_next     = rx_serr_reg;
        // after the mid-start sample the 4-bit counter wraps every 16 ticks, i.e. mid-bit
        rx_sample        = tick && (rx_tick_reg == 4'd15);
        if (tick)
            rx_tick_next = rx_tick_reg + 4'd1;
        case (rx_state_reg)
            S_IDLE: begin
                rx_tick_next = '0;
                if (!rx_sync_reg) begin
                    rx_state_next = S_START;
                    rx_mode_next  = parity_mode;
                    rx_perr_next  = 1'b0;
                    rx_bit_next   = '0;
                end
            end
            S_START: begin
                if (tick && (rx_tick_reg == 4'd7)) begin
                    rx_tick_next  = '0;
                    rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_sample) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_W-1:1]};
                    if (rx_bit_reg == 4'(DATA_W - 1))
                        rx_state_next = (rx_mode_reg[0] ^ rx_mode_reg[1]) ? S_PARITY : S_STOP;
                    else
                        rx_bit_next = rx_bit_reg + 4'd1;
                end
            end
            S_PARITY: begin
                if (rx_sample) begin
                    rx_perr_next  = rx_sync_reg ^ (^rx_shift_reg) ^ rx_mode_reg[1];
                    rx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_sample) begin
                    rx_state_next    = S_IDLE;
                    rx_valid_next    = 1'b1;
                    rx_data_next     = rx_shift_reg;
                    rx_perr_out_next = rx_perr_reg;
                    rx_serr_next     = ~rx_sync_reg;
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg     <= 1'b1;
            rx_sync_reg     <= 1'b1;
            rx_state_reg    <= S_IDLE;
            rx_tick_reg     <= '0;
            rx_bit_reg      <= '0;
            rx_shift_reg    <= '0;
            rx_data_reg     <= '0;
            rx_mode_reg     <= '0;
            rx_perr_reg     <= 1'b0;
            rx_valid_reg    <= 1'b0;
            rx_perr_out_reg <= 1'b0;
            rx_serr_reg     <= 1'b0;
        end else begin
            rx_meta_reg     <= rx_src;
            rx_sync_reg     <= rx_meta_reg;
            rx_state_reg    <= rx_state_next;
            rx_tick_reg     <= rx_tick_next;
            rx_bit_reg      <= rx_bit_next;
            rx_shift_reg    <= rx_shift_next;
            rx_data_reg     <= rx_data_next;
            rx_mode_reg     <= rx_mode_next;
            rx_perr_reg     <= rx_perr_next;
            rx_valid_reg    <= rx_valid_next;
            rx_perr_out_reg <= rx_perr_out_next;
            rx_serr_reg     <= rx_serr_next;
        end
    end

`ifdef UART_LOOPBACK_EN
    assign rx_src  = loopback ? tx_out_reg : rx_line;
    assign tx_line = loopback ? 1'b1 : tx_out_reg;
`else
    assign rx_src  = rx_line;
    assign tx_line = tx_out_reg;
`endif

    assign tx_ready      = tx_ready_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_data       = rx_data_reg;
    assign rx_parity_err = rx_perr_out_reg;
    assign rx_stop_err   = rx_serr_reg;

endmodule

// File: tb/tb_uart_core_param.sv
// Randomized bench for uart_core_param: TX bit stream and RX results checked against a frame-level model.
module tb_uart_core_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_sel, parity_mode;
    logic       stop2, tx_valid, tx_ready, tx_line, rx_line, rx_valid;
    logic [7:0] tx_data, rx_data;
    logic       rx_parity_err, rx_stop_err;
    logic       wire_mode, bench_rx;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] rx_q[$];

    assign rx_line = wire_mode ? tx_line : bench_rx;

    always #5 clk = ~clk;

    uart_core_param #(
        .DATA_W(8), .DIV_W(16), .BAUD_DIV0(1), .BAUD_DIV1(2), .BAUD_DIV2(3), .BAUD_DIV3(4)
    ) dut (
        .clk(clk), .rst(rst), .baud_sel(baud_sel), .parity_mode(parity_mode), .stop2(stop2),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_line(tx_line),
        .rx_line(rx_line), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_parity_err(rx_parity_err), .rx_stop_err(rx_stop_err)
    );

    // every cycle rx_valid is high records one delivered frame {stop_err, parity_err, data}
    always @(negedge clk) if (rx_valid) rx_q.push_back({rx_stop_err, rx_parity_err, rx_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic parity_on(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    // Parity bit that makes the total count of ones even (mode 01) or odd (mode 10).
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] pm);
        logic ones_odd;
        ones_odd = ($countones(d) % 2) == 1;
        return (pm == 2'b10) ? ~ones_odd : ones_odd;
    endfunction

    // Line level of every bit of a frame, start bit first; returns the bit count.
    function automatic int build_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                       input logic flip, input logic stop_lvl, output logic [15:0] bits);
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (parity_on(pm)) begin
            bits[n] = parity_bit(d, pm) ^ flip;
            n++;
        end
        bits[n] = stop_lvl;
        n++;
        if (s2) n++;
        return n;
    endfunction

    task automatic check_rx(input string tag, input logic [7:0] d, input logic perr, input logic serr);
        logic [9:0] r;
        check({tag, " rx count"}, 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            check({tag, " rx data"}, 32'(r[7:0]), 32'(d));
            check({tag, " rx perr"}, 32'(r[8]), 32'(perr));
            check({tag, " rx serr"}, 32'(r[9]), 32'(serr));
        end
        rx_q.delete();
    endtask

    // Sends one word through the TX handshake and checks every bit mid-way plus the frame length.
    task automatic tx_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2, input int bp,
                            input logic hold, input logic [7:0] next_d);
        logic [15:0] bits;
        int n, c, lim;
        logic ok;
        n = build_frame(d, pm, s2, 1'b0, 1'b1, bits);
        @(negedge clk);
        parity_mode = pm;
        stop2 = s2;
        tx_data = d;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            else @(negedge clk);
        end
        check("tx accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (hold) tx_data = next_d;
        else tx_valid = 1'b0;
        c = -1;
        for (int k = 0; k < n; k++) begin
            while (c < k * bp + bp / 2) begin
                @(negedge clk);
                c++;
            end
            check($sformatf("tx bit%0d", k), 32'(tx_line), 32'(bits[k]));
        end
        lim = n * bp + 100;
        while (!tx_ready && c < lim) begin
            @(negedge clk);
            c++;
        end
        if (bp == 16) check("tx frame len", 32'(c), 32'(n * bp));
        else check("tx frame len near", 32'((c >= n * bp - 1) && (c <= n * bp)), 32'd1);
        $display("tx frame data=%02h pm=%0d stop2=%0d bits=%0d cycles=%0d", d, pm, s2, n, c);
        if (wire_mode) check_rx("loop", d, 1'b0, 1'b0);
    endtask

    // Drives one frame onto rx_line from the bench and checks the delivered result.
    task automatic rx_frame(input logic [7:0] d, input logic [1:0] pm, input logic flip, input logic stop_lvl);
        logic [15:0] bits;
        int n;
        n = build_frame(d, pm, 1'b0, flip, stop_lvl, bits);
        @(negedge clk);
        parity_mode = pm;
        for (int k = 0; k < n; k++) begin
            bench_rx = bits[k];
            repeat (16) @(negedge clk);
        end
        bench_rx = 1'b1;
        repeat (40) @(negedge clk);
        $display("rx frame data=%02h pm=%0d flip=%0d stop=%0d", d, pm, flip, stop_lvl);
        check_rx("bench", d, parity_on(pm) && flip, ~stop_lvl);
    endtask

    initial begin
        logic [7:0] w1, w2;
        rst = 1'b1;
        baud_sel = 2'd0;
        parity_mode = 2'd0;
        stop2 = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        wire_mode = 1'b1;
        bench_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst tx_line", 32'(tx_line), 32'd1);
        check("rst tx_ready", 32'(tx_ready), 32'd0);
        check("rst rx_valid", 32'(rx_valid), 32'd0);
        check("rst rx_data", 32'(rx_data), 32'd0);
        check("rst errs", 32'({rx_parity_err, rx_stop_err}), 32'd0);
        rst = 1'b0;
        #1;
        check("tx_ready before edge", 32'(tx_ready), 32'd0);
        @(negedge clk);
        check("tx_ready after edge", 32'(tx_ready), 32'd1);

        tx_frame(8'h21, 2'b00, 1'b0, 16, 1'b0, 8'h00);
        tx_frame(8'hA5, 2'b01, 1'b0, 16, 1'b0, 8'h00);
        tx_frame(8'hA5, 2'b10, 1'b0, 16, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++)
            tx_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16, 1'b0, 8'h00);
        @(negedge clk);
        baud_sel = 2'd1;
        tx_frame(8'($urandom), 2'b01, 1'b0, 32, 1'b0, 8'h00);
        @(negedge clk);
        baud_sel = 2'd0;

        wire_mode = 1'b0;
        repeat (20) @(negedge clk);
        rx_frame(8'hA5, 2'b01, 1'b1, 1'b1);
        rx_frame(8'hA5, 2'b10, 1'b1, 1'b1);
        rx_frame(8'h3C, 2'b00, 1'b0, 1'b0);
        bench_rx = 1'b0;
        repeat (4) @(negedge clk);
        bench_rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch no rx_valid", 32'(rx_q.size()), 32'd0);
        rx_q.delete();
        rx_frame(8'h5A, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            rx_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0));

        wire_mode = 1'b1;
        repeat (20) @(negedge clk);
        w1 = 8'($urandom);
        w2 = 8'($urandom) & 8'hFB;
        tx_frame(w1, 2'b00, 1'b1, 16, 1'b1, w2);
        @(negedge clk);
        check("b2b start bit", 32'(tx_line), 32'd0);
        check("b2b ready one cycle", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        repeat (56) @(negedge clk);
        check("f2 data bit2", 32'(tx_line), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst tx_line", 32'(tx_line), 32'd1);
        check("mid rst tx_ready", 32'(tx_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("mid rst no rx_valid", 32'(rx_q.size()), 32'd0);
        check("mid rst tx idle", 32'({tx_line, tx_ready}), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
